multicycle_ctrl: RTL and testbench

//  Control FSM that runs the MIPS datapath (PC, InstructionMemory, RegFile,

---
 rtl/mips_ctrl_pkg.sv | 47 ++++
 rtl/mem_wait_timer.sv | 43 ++++
 rtl/multicycle_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, the FSM
// state encoding, and the alu_op / alu_src_b / pc_source select codes.
package mips_ctrl_pkg;

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    ST_FETCH     = 4'd0,
    ST_DECODE    = 4'd1,
    ST_MEM_ADDR  = 4'd2,
    ST_MEM_RD    = 4'd3,
    ST_MEM_WB    = 4'd4,
    ST_MEM_WR    = 4'd5,
    ST_R_EXEC    = 4'd6,
    ST_R_WB      = 4'd7,
    ST_ADDI_EXEC = 4'd8,
    ST_ADDI_WB   = 4'd9,
    ST_BRANCH    = 4'd10,
    ST_JUMP      = 4'd11
  } ctrl_state_e;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_READ2   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // States that hold a memory request open until mem_ready
  function automatic logic is_mem_wait_state(input ctrl_state_e s);
    return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_ready and flags the cycle
// in which the wait reaches MEM_TIMEOUT.
//   clk, reset  : clock, async active-high reset
//   count_en    : a memory request is open and mem_ready is low this cycle
//   clear       : restart the count (taken on timeout)
//   timeout_c   : combinational, high in the MEM_TIMEOUT-th waiting cycle
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic timeout_c
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // cnt_q holds the number of waiting cycles already completed
  assign timeout_c = count_en && (cnt_q == CW'(MEM_TIMEOUT - 1));

  // Any cycle without a pending wait restarts the count, which also covers
  // every state change out of a waiting state
  always_comb begin
    cnt_d = cnt_q;
    if (clear || !count_en) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control FSM. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready, aborts stalled accesses
// after MEM_TIMEOUT cycles and counts retired instructions.
//   inputs : clk, reset (async, active-high), opcode, funct, zero, mem_ready
//   outputs: datapath controls (Moore decode of state; ir_write/pc_write in
//            FETCH qualified by mem_ready), illegal_op / mem_err one-cycle
//            registered pulses, retired instruction count
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic             mem_err,
  output logic [CNT_W-1:0] retired
);

  ctrl_state_e      state_q, state_d;
  logic             illegal_op_q, illegal_op_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire_c;
  logic             wait_en_c;
  logic             timeout_c;

  // funct goes straight to the ALU control; zero is gated in the datapath
  logic unused_c;
  assign unused_c = ^{funct, zero};

  assign wait_en_c = is_mem_wait_state(state_q) && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .reset    (reset),
    .count_en (wait_en_c),
    .clear    (timeout_c),
    .timeout_c(timeout_c)
  );

  // Next-state, pulse flags and retirement
  always_comb begin
    state_d      = state_q;
    illegal_op_d = 1'b0;
    mem_err_d    = 1'b0;
    retire_c     = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout_c) begin
          // PC untouched, so returning to FETCH retries the same fetch
          state_d   = ST_FETCH;
          mem_err_d = 1'b1;
        end
      end
      ST_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_RTYPE:     state_d = ST_R_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EXEC;
          default: begin
            state_d      = ST_FETCH;
            illegal_op_d = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: state_d = (opcode == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (mem_ready) begin
          state_d = ST_MEM_WB;
        end else if (timeout_c) begin
          state_d   = ST_FETCH;
          mem_err_d = 1'b1;
        end
      end
      ST_MEM_WB: begin
        state_d  = ST_FETCH;
        retire_c = 1'b1;
      end
      ST_MEM_WR: begin
        if (mem_ready) begin
          state_d  = ST_FETCH;
          retire_c = 1'b1;
        end else if (timeout_c) begin
          state_d   = ST_FETCH;
          mem_err_d = 1'b1;
        end
      end
      ST_R_EXEC:    state_d = ST_R_WB;
      ST_ADDI_EXEC: state_d = ST_ADDI_WB;
      ST_R_WB, ST_ADDI_WB, ST_BRANCH, ST_JUMP: begin
        state_d  = ST_FETCH;
        retire_c = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Counter wraps naturally modulo 2^CNT_W
  always_comb begin
    retired_d = retired_q;
    if (retire_c) begin
      retired_d = retired_q + CNT_W'(1);
    end
  end

  // Datapath control decode
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRC_B_READ2;
    alu_op        = ALU_OP_ADD;
    pc_source     = PC_SRC_ALU;
    unique case (state_q)
      ST_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: alu_src_b = SRC_B_IMM_SH2;
      ST_MEM_ADDR, ST_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      ST_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      ST_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      ST_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_ADDI_WB: reg_write = 1'b1;
      ST_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PC_SRC_ALUOUT;
      end
      ST_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PC_SRC_JUMP;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      illegal_op_q <= 1'b0;
      mem_err_q    <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
      mem_err_q    <= mem_err_d;
      retired_q    <= retired_d;
    end
  end

  assign illegal_op = illegal_op_q;
  assign mem_err    = mem_err_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl. The reference model walks each
// instruction as a list of phases derived from its opcode, decides
// mem_ready itself, and predicts controls, pulses, latency and retirement.
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 32;

  localparam int PH_FETCH = 0, PH_DECODE = 1, PH_ADDR = 2, PH_RD = 3,
                 PH_MWB = 4, PH_WR = 5, PH_REXE = 6, PH_RWB = 7,
                 PH_IEXE = 8, PH_IWB = 9, PH_BR = 10, PH_J = 11;

  logic             clk = 1'b0;
  logic             reset;
  logic [5:0]       opcode, funct;
  logic             zero, mem_ready;
  logic             pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic             ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]       alu_src_b, alu_op, pc_source;
  logic             illegal_op, mem_err;
  logic [CNT_W-1:0] retired;

  multicycle_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .illegal_op(illegal_op),
    .mem_err(mem_err), .retired(retired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [CNT_W-1:0] exp_retired = '0;
  logic             pend_ill = 1'b0;
  logic             pend_err = 1'b0;

  logic [15:0] got_vec;
  assign got_vec = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                    reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                    alu_op, pc_source};

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic pcw, pcwc, io, mr, mw, irw,
                                     rd, m2r, rw, sa, input logic [1:0] sb,
                                     input logic [1:0] op, input logic [1:0] ps);
    return {pcw, pcwc, io, mr, mw, irw, rd, m2r, rw, sa, sb, op, ps};
  endfunction

  // Expected control word for each phase, straight from the control table
  function automatic logic [15:0] exp_vec(input int ph, input logic rdy);
    case (ph)
      PH_FETCH:  return mk(rdy,0,0,1,0,rdy,0,0,0,0, 2'b01, 2'b00, 2'b00);
      PH_DECODE: return mk(0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00);
      PH_ADDR:   return mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
      PH_RD:     return mk(0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
      PH_MWB:    return mk(0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00);
      PH_WR:     return mk(0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00);
      PH_REXE:   return mk(0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00);
      PH_RWB:    return mk(0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00);
      PH_IEXE:   return mk(0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00);
      PH_IWB:    return mk(0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00);
      PH_BR:     return mk(0,1,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01);
      default:   return mk(1,0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10);
    endcase
  endfunction

  // One clock: drive inputs, check at the falling edge, advance past posedge
  task automatic cycle(input int ph, input logic rdy, input string tag);
    mem_ready = rdy;
    zero      = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq({tag, "/ctrl"}, 64'(got_vec), 64'(exp_vec(ph, rdy)));
    check_eq({tag, "/illegal_op"}, 64'(illegal_op), 64'(pend_ill));
    check_eq({tag, "/mem_err"}, 64'(mem_err), 64'(pend_err));
    check_eq({tag, "/retired"}, 64'(retired), 64'(exp_retired));
    pend_ill = 1'b0;
    pend_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // A memory phase with w low cycles before ready; w >= MEM_TIMEOUT aborts
  task automatic mem_phase(input int ph, input int w, input string tag,
                           output bit aborted, inout int cyc);
    int n;
    n = (w >= int'(MEM_TIMEOUT)) ? int'(MEM_TIMEOUT) : w + 1;
    for (int c = 0; c < n; c++) begin
      cycle(ph, logic'(c == w), tag);
      cyc++;
    end
    aborted = (w >= int'(MEM_TIMEOUT));
    if (aborted) pend_err = 1'b1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                           input string tag, output int cyc);
    bit ab;
    opcode = op;
    funct  = 6'($urandom);
    cyc    = 0;
    mem_phase(PH_FETCH, wf, tag, ab, cyc);
    if (ab) return;
    cycle(PH_DECODE, rnd_bit(), tag); cyc++;
    case (op)
      OP_LW: begin
        cycle(PH_ADDR, rnd_bit(), tag); cyc++;
        mem_phase(PH_RD, wm, tag, ab, cyc);
        if (ab) return;
        cycle(PH_MWB, rnd_bit(), tag); cyc++;
      end
      OP_SW: begin
        cycle(PH_ADDR, rnd_bit(), tag); cyc++;
        mem_phase(PH_WR, wm, tag, ab, cyc);
        if (ab) return;
      end
      OP_RTYPE: begin
        cycle(PH_REXE, rnd_bit(), tag); cyc++;
        cycle(PH_RWB, rnd_bit(), tag); cyc++;
      end
      OP_ADDI: begin
        cycle(PH_IEXE, rnd_bit(), tag); cyc++;
        cycle(PH_IWB, rnd_bit(), tag); cyc++;
      end
      OP_BEQ: begin cycle(PH_BR, rnd_bit(), tag); cyc++; end
      OP_J:   begin cycle(PH_J, rnd_bit(), tag); cyc++; end
      default: begin
        pend_ill = 1'b1;
        return;
      end
    endcase
    exp_retired = exp_retired + CNT_W'(1);
  endtask

  function automatic int rnd_wait();
    return ($urandom_range(0, 19) == 0) ? int'(MEM_TIMEOUT) : int'($urandom_range(0, 3));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    logic [5:0] ops [8];
    ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, 6'b111111, 6'b001101};

    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset/ctrl", 64'(got_vec), 64'(exp_vec(PH_FETCH, 1'b0)));
    check_eq("reset/retired", 64'(retired), 64'd0);
    check_eq("reset/illegal_op", 64'(illegal_op), 64'd0);
    check_eq("reset/mem_err", 64'(mem_err), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // add: 4 cycles, retires one
    funct = 6'b100000;
    run_instr(OP_RTYPE, 0, 0, "add", cyc);
    check_eq("add/latency", 64'(cyc), 64'd4);
    // lw with 3 stall cycles in the read
    run_instr(OP_LW, 0, 3, "lw_stall", cyc);
    check_eq("lw_stall/latency", 64'(cyc), 64'd8);
    run_instr(OP_SW, 0, 0, "sw", cyc);
    check_eq("sw/latency", 64'(cyc), 64'd4);
    run_instr(OP_BEQ, 0, 0, "beq1", cyc);
    check_eq("beq1/latency", 64'(cyc), 64'd3);
    run_instr(OP_BEQ, 0, 0, "beq0", cyc);
    check_eq("beq0/latency", 64'(cyc), 64'd3);
    run_instr(OP_J, 0, 0, "j", cyc);
    check_eq("j/latency", 64'(cyc), 64'd3);
    run_instr(OP_ADDI, 0, 0, "addi", cyc);
    check_eq("addi/latency", 64'(cyc), 64'd4);
    run_instr(6'b111111, 0, 0, "illegal", cyc);
    check_eq("illegal/latency", 64'(cyc), 64'd2);
    // Fetch stuck: abort after MEM_TIMEOUT waiting cycles, then retry
    run_instr(OP_RTYPE, MEM_TIMEOUT, 0, "fetch_to", cyc);
    check_eq("fetch_to/latency", 64'(cyc), 64'(MEM_TIMEOUT));
    run_instr(OP_RTYPE, 0, 0, "retry", cyc);
    run_instr(OP_SW, 0, MEM_TIMEOUT, "sw_to", cyc);
    run_instr(OP_J, 0, 0, "after_to", cyc);

    for (int i = 0; i < 300; i++) begin
      run_instr(ops[$urandom_range(0, 7)], rnd_wait(), rnd_wait(), "rand", cyc);
    end

    // Reset in the middle of R_EXEC
    opcode = OP_RTYPE;
    cycle(PH_FETCH, 1'b1, "rst_mid");
    cycle(PH_DECODE, 1'b0, "rst_mid");
    mem_ready = 1'b0;
    #1 reset = 1'b1;
    @(negedge clk);
    check_eq("rst_mid/ctrl", 64'(got_vec), 64'(exp_vec(PH_FETCH, 1'b0)));
    check_eq("rst_mid/retired", 64'(retired), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_retired = '0;
    pend_ill = 1'b0;
    pend_err = 1'b0;
    cycle(PH_FETCH, 1'b0, "rst_after");
    check_eq("rst_after/reg_write", 64'(reg_write), 64'd0);
    run_instr(OP_RTYPE, 0, 0, "post_rst", cyc);
    @(negedge clk);
    check_eq("post_rst/retired", 64'(retired), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
